// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, oversample ratio and baud divider helper.
package uart_pkg;

  localparam int unsigned OVERSAMPLE = 16;
  localparam int unsigned ST_W       = 3;

  typedef logic [ST_W-1:0] state_t;

  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_START  = 3'd1;
  localparam state_t ST_DATA   = 3'd2;
  localparam state_t ST_STOP   = 3'd3;
  localparam state_t ST_BREAK  = 3'd4;
  localparam state_t ST_PARITY = 3'd5;

  // Clock cycles per oversample tick, floor division.
  function automatic int unsigned calc_div(input int unsigned clk_freq, input int unsigned baud);
    return clk_freq / (baud * OVERSAMPLE);
  endfunction

endpackage

// File: rtl/baud_tick_gen.sv
// Free-running divider producing a one-cycle tick every DIV clocks; shared by the UART rx and tx.
module baud_tick_gen #(
  parameter int unsigned DIV = 325
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_next;

  always_comb begin
    cnt_next = (cnt == LAST) ? '0 : cnt + CW'(1);
  end

  // tick is registered from cnt_next so it is high exactly while cnt == DIV-1.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      cnt  <= cnt_next;
      tick <= (cnt_next == LAST);
    end
  end

endmodule

// File: rtl/uart_rx_byte.sv
// 16x oversampling UART receiver, 8N1 LSB first, one-cycle strobe per byte into the FIFO.
// Optional even-parity checking is enabled by defining UART_RX_PARITY_EN.
module uart_rx_byte
  import uart_pkg::*;
#(
  parameter int unsigned DATA_SIZE  = 8,
  parameter int unsigned CLK_FREQ   = 50000000,
  parameter int unsigned BAUD       = 9600,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned STOP_TICKS = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx,
  output logic [DATA_SIZE-1:0] rx_data,
  output logic                 rx_done_tick,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 busy
);

  localparam int unsigned DIV   = calc_div(CLK_FREQ, BAUD);
  localparam int unsigned S_MAX = (STOP_TICKS > OVERSAMPLE) ? STOP_TICKS : OVERSAMPLE;
  localparam int unsigned S_W   = $clog2(S_MAX);
  localparam int unsigned N_W   = (DATA_SIZE > 1) ? $clog2(DATA_SIZE) : 1;

  localparam logic [S_W-1:0] S_MID  = S_W'(OVERSAMPLE / 2 - 1);
  localparam logic [S_W-1:0] S_BIT  = S_W'(OVERSAMPLE - 1);
  localparam logic [S_W-1:0] S_STOP = S_W'(STOP_TICKS - 1);
  localparam logic [N_W-1:0] N_LAST = N_W'(DATA_SIZE - 1);

  logic                 rx_meta;
  logic                 rx_s;
  logic                 tick;
  state_t               state;
  state_t               state_next;
  logic [S_W-1:0]       s;
  logic [S_W-1:0]       s_next;
  logic [N_W-1:0]       n;
  logic [N_W-1:0]       n_next;
  logic [DATA_SIZE-1:0] sh;
  logic [DATA_SIZE-1:0] sh_next;
  logic [DATA_SIZE-1:0] data_next;
  logic                 done_next;
  logic                 ferr_next;
`ifdef UART_RX_PARITY_EN
  logic                 par_bad;
  logic                 par_bad_next;
  logic                 perr_next;
`endif

  baud_tick_gen #(
    .DIV (DIV)
  ) u_tick (
    .clk   (clk),
    .reset (reset),
    .tick  (tick)
  );

  // Two-flop synchronizer; idle-high reset keeps a reset release from looking like a start bit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (!rx_s) state_next = ST_START;
      ST_START: if (tick && s == S_MID) state_next = rx_s ? ST_IDLE : ST_DATA;
      ST_DATA: begin
        if (tick && s == S_BIT && n == N_LAST) begin
`ifdef UART_RX_PARITY_EN
          state_next = ST_PARITY;
`else
          state_next = ST_STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: if (tick && s == S_BIT) state_next = ST_STOP;
`endif
      ST_STOP:  if (tick && s == S_STOP) state_next = rx_s ? ST_IDLE : ST_BREAK;
      ST_BREAK: if (rx_s) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Counter, shift register and pulse next-values.
  always_comb begin
    s_next    = s;
    n_next    = n;
    sh_next   = sh;
    data_next = rx_data;
    done_next = 1'b0;
    ferr_next = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_next = par_bad;
    perr_next    = 1'b0;
`endif
    case (state)
      ST_IDLE: begin
        s_next = '0;
        n_next = '0;
      end
      ST_START: begin
        if (tick) begin
          if (s == S_MID) begin
            s_next = '0;
            n_next = '0;
          end else begin
            s_next = s + S_W'(1);
          end
        end
      end
      ST_DATA: begin
        if (tick) begin
          if (s == S_BIT) begin
            s_next  = '0;
            sh_next = {rx_s, sh[DATA_SIZE-1:1]};
            if (n != N_LAST) n_next = n + N_W'(1);
          end else begin
            s_next = s + S_W'(1);
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (tick) begin
          if (s == S_BIT) begin
            s_next       = '0;
            par_bad_next = ^{sh, rx_s};
          end else begin
            s_next = s + S_W'(1);
          end
        end
      end
`endif
      ST_STOP: begin
        if (tick) begin
          if (s == S_STOP) begin
            s_next = '0;
            if (rx_s) begin
              data_next = sh;
              done_next = 1'b1;
`ifdef UART_RX_PARITY_EN
              perr_next = par_bad;
`endif
            end else begin
              ferr_next = 1'b1;
            end
          end else begin
            s_next = s + S_W'(1);
          end
        end
      end
      default: s_next = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s            <= '0;
      n            <= '0;
      sh           <= '0;
      rx_data      <= '0;
      rx_done_tick <= 1'b0;
      frame_err    <= 1'b0;
      busy         <= 1'b0;
    end else begin
      s            <= s_next;
      n            <= n_next;
      sh           <= sh_next;
      rx_data      <= data_next;
      rx_done_tick <= done_next;
      frame_err    <= ferr_next;
      busy         <= (state_next != ST_IDLE);
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      par_bad    <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      par_bad    <= par_bad_next;
      parity_err <= perr_next;
    end
  end
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_byte.sv
// Directed self-checking bench for uart_rx_byte at DIV = 10 (160 clk per bit).
module tb_uart_rx_byte;

  localparam int BIT_CLK = 160;
`ifdef UART_RX_PARITY_EN
  localparam int LAT_LO = 1500 + BIT_CLK;
  localparam int LAT_HI = 1560 + BIT_CLK;
`else
  localparam int LAT_LO = 1500;
  localparam int LAT_HI = 1560;
`endif

  logic       clk   = 1'b0;
  logic       reset = 1'b0;
  logic       rx    = 1'b1;
  logic [7:0] rx_data;
  logic       rx_done_tick;
  logic       frame_err;
  logic       parity_err;
  logic       busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cnt = 0;
  int ferr_cnt = 0;
  int perr_cnt = 0;
  int last_done_cyc = 0;
  int last_perr_cyc = -1;
  logic [7:0] last_byte = 8'h00;
  logic [7:0] got_q[$];

  uart_rx_byte #(
    .DATA_SIZE  (8),
    .CLK_FREQ   (1600000),
    .BAUD       (10000),
    .OVERSAMPLE (16),
    .STOP_TICKS (16)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .rx           (rx),
    .rx_data      (rx_data),
    .rx_done_tick (rx_done_tick),
    .frame_err    (frame_err),
    .parity_err   (parity_err),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  // Pulse monitor sampled on the falling edge.
  always @(negedge clk) begin
    cyc++;
    if (rx_done_tick === 1'b1) begin
      done_cnt++;
      last_byte     = rx_data;
      last_done_cyc = cyc;
      got_q.push_back(rx_data);
    end
    if (frame_err === 1'b1) ferr_cnt++;
    if (parity_err === 1'b1) begin
      perr_cnt++;
      last_perr_cyc = cyc;
    end
  end

  task automatic drive_bit(input logic v);
    rx = v;
    repeat (BIT_CLK) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_v, input logic par_v,
                            output int start_cyc);
    start_cyc = cyc;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit(par_v);
`endif
    drive_bit(stop_v);
    rx = 1'b1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 16; i++) begin
      rx = i[0];
      @(negedge clk);
      checks++;
      if ({rx_done_tick, frame_err, parity_err, busy} !== 4'b0000) begin
        errors++;
        $display("FAIL reset_pulses: got %b want 0000", {rx_done_tick, frame_err, parity_err, busy});
      end
      checks++;
      if (rx_data !== 8'h00) begin
        errors++;
        $display("FAIL reset_data: got %h want 00", rx_data);
      end
    end
    rx = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    repeat (30) @(negedge clk);
  endtask

  task automatic test_single();
    int d0, f0, t0, lat;
    d0 = done_cnt;
    f0 = ferr_cnt;
    send_frame(8'hA5, 1'b1, 1'b0, t0);
    repeat (20) @(negedge clk);
    lat = last_done_cyc - t0;
    checks++;
    if (done_cnt - d0 !== 1) begin
      errors++;
      $display("FAIL single_count: got %0d want 1", done_cnt - d0);
    end
    checks++;
    if (last_byte !== 8'hA5) begin
      errors++;
      $display("FAIL single_data: got %h want a5", last_byte);
    end
    checks++;
    if (lat < LAT_LO || lat > LAT_HI) begin
      errors++;
      $display("FAIL single_latency: got %0d want %0d..%0d", lat, LAT_LO, LAT_HI);
    end
    checks++;
    if (ferr_cnt - f0 !== 0) begin
      errors++;
      $display("FAIL single_frame_err: got %0d want 0", ferr_cnt - f0);
    end
  endtask

  task automatic test_glitch();
    int d0, k, t0;
    d0 = done_cnt;
    rx = 1'b0;
    repeat (30) @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL glitch_busy_high: got %b want 1", busy);
    end
    rx = 1'b1;
    k = 0;
    while (busy !== 1'b0 && k < 80) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL glitch_busy_drop: got %b want 0 within 80 clk", busy);
    end
    repeat (40) @(negedge clk);
    checks++;
    if (done_cnt - d0 !== 0) begin
      errors++;
      $display("FAIL glitch_no_done: got %0d want 0", done_cnt - d0);
    end
    send_frame(8'h5A, 1'b1, 1'b0, t0);
    repeat (20) @(negedge clk);
    checks++;
    if (done_cnt - d0 !== 1 || last_byte !== 8'h5A) begin
      errors++;
      $display("FAIL glitch_next_frame: got count %0d data %h want 1 5a", done_cnt - d0, last_byte);
    end
  endtask

  task automatic test_frame_err();
    int d0, f0, k, t0;
    d0 = done_cnt;
    f0 = ferr_cnt;
    send_frame(8'h3C, 1'b0, 1'b0, t0);
    rx = 1'b0;
    repeat (500) @(negedge clk);
    checks++;
    if (ferr_cnt - f0 !== 1) begin
      errors++;
      $display("FAIL ferr_pulse: got %0d cycles want 1", ferr_cnt - f0);
    end
    checks++;
    if (done_cnt - d0 !== 0) begin
      errors++;
      $display("FAIL ferr_no_done: got %0d want 0", done_cnt - d0);
    end
    checks++;
    if (rx_data !== 8'h5A) begin
      errors++;
      $display("FAIL ferr_data_kept: got %h want 5a", rx_data);
    end
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL ferr_busy_held: got %b want 1", busy);
    end
    rx = 1'b1;
    k = 0;
    while (busy !== 1'b0 && k < 10) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL ferr_busy_release: got %b want 0", busy);
    end
    repeat (40) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int d0, t0;
    logic [7:0] exp_b[3];
    logic [7:0] got;
    exp_b[0] = 8'h00;
    exp_b[1] = 8'hFF;
    exp_b[2] = 8'h55;
    got_q.delete();
    d0 = done_cnt;
    for (int i = 0; i < 3; i++) send_frame(exp_b[i], 1'b1, ^exp_b[i], t0);
    repeat (40) @(negedge clk);
    checks++;
    if (done_cnt - d0 !== 3) begin
      errors++;
      $display("FAIL b2b_count: got %0d want 3", done_cnt - d0);
    end
    for (int i = 0; i < 3; i++) begin
      got = (got_q.size() > i) ? got_q[i] : 8'hxx;
      checks++;
      if (got !== exp_b[i]) begin
        errors++;
        $display("FAIL b2b_data%0d: got %h want %h", i, got, exp_b[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int d0, f0, t0;
    logic [7:0] b;
    b  = 8'h81;
    d0 = done_cnt;
    f0 = ferr_cnt;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(b[i]);
    rx = b[4];
    repeat (BIT_CLK / 2) @(negedge clk);
    reset = 1'b0;
    rx    = 1'b1;
    repeat (20) @(negedge clk);
    checks++;
    if ({busy, rx_done_tick, frame_err} !== 3'b000 || rx_data !== 8'h00) begin
      errors++;
      $display("FAIL rstmid_in_reset: got busy/done/ferr %b data %h want 000 00",
               {busy, rx_done_tick, frame_err}, rx_data);
    end
    reset = 1'b1;
    repeat (200) @(negedge clk);
    checks++;
    if (done_cnt - d0 !== 0 || ferr_cnt - f0 !== 0) begin
      errors++;
      $display("FAIL rstmid_no_pulses: got done %0d ferr %0d want 0 0", done_cnt - d0, ferr_cnt - f0);
    end
    send_frame(b, 1'b1, ^b, t0);
    repeat (20) @(negedge clk);
    checks++;
    if (done_cnt - d0 !== 1 || last_byte !== 8'h81) begin
      errors++;
      $display("FAIL rstmid_next_frame: got count %0d data %h want 1 81", done_cnt - d0, last_byte);
    end
  endtask

  task automatic test_parity();
    checks++;
    if (perr_cnt !== 0) begin
      errors++;
      $display("FAIL parity_clean: got %0d pulses want 0", perr_cnt);
    end
`ifdef UART_RX_PARITY_EN
    begin
      int d0, p0, t0;
      d0 = done_cnt;
      p0 = perr_cnt;
      send_frame(8'h07, 1'b1, 1'b0, t0);
      repeat (20) @(negedge clk);
      checks++;
      if (done_cnt - d0 !== 1 || last_byte !== 8'h07) begin
        errors++;
        $display("FAIL parity_delivered: got count %0d data %h want 1 07", done_cnt - d0, last_byte);
      end
      checks++;
      if (perr_cnt - p0 !== 1 || last_perr_cyc !== last_done_cyc) begin
        errors++;
        $display("FAIL parity_err_pulse: got %0d pulses at %0d want 1 at %0d",
                 perr_cnt - p0, last_perr_cyc, last_done_cyc);
      end
    end
`endif
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_glitch();
    test_frame_err();
    test_back_to_back();
    test_reset_mid();
    test_parity();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
